// File: rtl/dyn_partition_trace_gen.sv
// -----------------------------------------------------------------------------
// dyn_partition_trace_gen
//
// Purpose:
//   Trace generator for the small dynamic-partition system. The system state is
//   two CNT_W-bit counters A and B and a 2-bit Johnson phase register m. The
//   phase chooses which counter increments on each step. Starting from the
//   all-zero state, this block steps the machine and streams one frame
//   {next_state, cur_state} per step to a downstream transition checker over a
//   valid/ready interface. An XOR mask can corrupt the emitted next-state field
//   so that the checker's rejection path can be exercised. The mask never
//   affects the internal state.
//
//   State vector layout, from bit 0 upward: A, B, m0, m1.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   one-cycle run request; only honoured while idle
//   num_steps   in   number of frames to emit; sampled with start
//   inject_mask in   XOR mask for the emitted next-state field; sampled with start
//   abort       in   synchronous run cancel
//   out_valid   out  frame available
//   out_ready   in   consumer accepts the frame
//   out_frame   out  [ST_W-1:0] = cur_state, [2*ST_W-1:ST_W] = next_state ^ mask
//   out_last    out  frame is the final one of the run
//   busy        out  not idle
//   done        out  one-cycle pulse at run completion
// -----------------------------------------------------------------------------
module dyn_partition_trace_gen #(
    parameter  int CNT_W  = 3,
    parameter  int STEP_W = 8,
    localparam int ST_W   = 2*CNT_W + 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [STEP_W-1:0]   num_steps,
    input  logic [ST_W-1:0]     inject_mask,
    input  logic                abort,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*ST_W-1:0]   out_frame,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t              fsm, fsm_next;
    logic [ST_W-1:0]   cur_state;
    logic [ST_W-1:0]   nxt_state;
    logic [STEP_W-1:0] count;
    logic [STEP_W-1:0] steps_q;
    logic [ST_W-1:0]   mask_q;
    logic              load;
    logic              adv;
    logic              last;

    // One step of the real machine: sel = m0 ^ m1 picks the counter, and the
    // phase advances as a 2-bit Johnson counter (00, 10, 11, 01).
    function automatic logic [ST_W-1:0] step_state(input logic [ST_W-1:0] s);
        logic [CNT_W-1:0] a;
        logic [CNT_W-1:0] b;
        logic             m0;
        logic             m1;
        a  = s[CNT_W-1:0];
        b  = s[2*CNT_W-1:CNT_W];
        m0 = s[2*CNT_W];
        m1 = s[2*CNT_W+1];
        if (m0 ^ m1)
            b = b + CNT_W'(1);
        else
            a = a + CNT_W'(1);
        return {m0, ~m1, b, a};
    endfunction

    assign nxt_state = step_state(cur_state);
    assign last      = (count == steps_q - STEP_W'(1));

    // Outputs depend on registered state only (done additionally on abort so
    // an abort in the DONE cycle suppresses the completion pulse).
    assign out_valid = (fsm == RUN);
    assign out_last  = (fsm == RUN) && last;
    assign out_frame = (fsm == RUN) ? {nxt_state ^ mask_q, cur_state} : '0;
    assign busy      = (fsm != IDLE);
    assign done      = (fsm == DONE) && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fsm <= IDLE;
        else
            fsm <= fsm_next;
    end

    always_comb begin
        fsm_next = fsm;
        load     = 1'b0;
        adv      = 1'b0;
        case (fsm)
            IDLE: begin
                // abort is meaningless here; start always takes effect.
                if (start) begin
                    if (num_steps != '0) begin
                        fsm_next = RUN;
                        load     = 1'b1;
                    end else begin
                        fsm_next = DONE;
                    end
                end
            end
            RUN: begin
                // Abort wins over a simultaneous handshake and freezes the state.
                if (abort) begin
                    fsm_next = IDLE;
                end else if (out_ready) begin
                    adv = 1'b1;
                    if (last)
                        fsm_next = DONE;
                end
            end
            DONE: fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= '0;
            count     <= '0;
            steps_q   <= '0;
            mask_q    <= '0;
        end else if (load) begin
            cur_state <= '0;
            count     <= '0;
            steps_q   <= num_steps;
            mask_q    <= inject_mask;
        end else if (adv) begin
            cur_state <= nxt_state;
            count     <= count + STEP_W'(1);
        end
    end

endmodule

// File: tb/tb_dyn_partition_trace_gen.sv
// -----------------------------------------------------------------------------
// tb_dyn_partition_trace_gen
//
// Purpose:
//   Directed self-checking bench for dyn_partition_trace_gen with CNT_W=3
//   (8-bit state, 16-bit frame). Expected frames come from a hand-computed
//   table of the 16-state cycle reached from the all-zero state.
// -----------------------------------------------------------------------------
module tb_dyn_partition_trace_gen;

    localparam int CNT_W  = 3;
    localparam int STEP_W = 8;
    localparam int ST_W   = 2*CNT_W + 2;

    // State sequence from zero: A in [2:0], B in [5:3], m0 at 6, m1 at 7.
    localparam logic [7:0] SEQ [16] = '{
        8'h00, 8'h41, 8'hC9, 8'h8A, 8'h12, 8'h53, 8'hDB, 8'h9C,
        8'h24, 8'h65, 8'hED, 8'hAE, 8'h36, 8'h77, 8'hFF, 8'hB8
    };

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [STEP_W-1:0]   num_steps;
    logic [ST_W-1:0]     inject_mask;
    logic                abort;
    logic                out_valid;
    logic                out_ready;
    logic [2*ST_W-1:0]   out_frame;
    logic                out_last;
    logic                busy;
    logic                done;

    int vectors;
    int miscompares;

    dyn_partition_trace_gen #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_steps   (num_steps),
        .inject_mask (inject_mask),
        .abort       (abort),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_frame   (out_frame),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_frame(input int i, input logic [7:0] mask);
        return {SEQ[(i + 1) % 16] ^ mask, SEQ[i % 16]};
    endfunction

    task automatic do_start(input int n, input logic [7:0] mask);
        start       = 1'b1;
        num_steps   = STEP_W'(n);
        inject_mask = mask;
        tick();
        start       = 1'b0;
        num_steps   = '0;
        inject_mask = '0;
    endtask

    // Run with out_ready held high and check every frame plus the done pulse.
    task automatic run_simple(input string tag, input int n, input logic [7:0] mask);
        out_ready = 1'b1;
        do_start(n, mask);
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s valid%0d", tag, i), out_valid, 1'b1);
            check_val($sformatf("%s frame%0d", tag, i), out_frame, exp_frame(i, mask));
            check_val($sformatf("%s last%0d", tag, i), out_last, (i == n - 1));
            check_val($sformatf("%s done_early%0d", tag, i), done, 1'b0);
            tick();
        end
        check_val({tag, " valid_after"}, out_valid, 1'b0);
        check_val({tag, " done_pulse"}, done, 1'b1);
        check_val({tag, " busy_in_done"}, busy, 1'b1);
        tick();
        check_val({tag, " done_clear"}, done, 1'b0);
        check_val({tag, " busy_clear"}, busy, 1'b0);
    endtask

    initial begin
        logic [5:0] pat;
        int         acc;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        num_steps   = '0;
        inject_mask = '0;
        abort       = 1'b0;
        out_ready   = 1'b0;

        // Reset state
        tick();
        tick();
        check_val("rst out_valid", out_valid, 1'b0);
        check_val("rst out_last", out_last, 1'b0);
        check_val("rst busy", busy, 1'b0);
        check_val("rst done", done, 1'b0);
        check_val("rst out_frame", out_frame, 16'h0000);
        rst_n = 1'b1;
        tick();

        // Basic 4-step run: {41,00} {C9,41} {8A,C9} {12,8A}
        run_simple("s1", 4, 8'h00);
        check_val("s1 idle_valid", out_valid, 1'b0);

        // Full wrap: the 17th frame repeats the first one
        run_simple("s2", 17, 8'h00);

        // Stalls with out_ready pattern 1,0,0,1,0,1
        pat = 6'b101001;
        acc = 0;
        out_ready = 1'b0;
        do_start(3, 8'h00);
        for (int c = 0; c < 6; c++) begin
            out_ready = pat[c];
            check_val($sformatf("s3 valid_c%0d", c), out_valid, 1'b1);
            check_val($sformatf("s3 frame_c%0d", c), out_frame, exp_frame(acc, 8'h00));
            check_val($sformatf("s3 last_c%0d", c), out_last, (acc == 2));
            check_val($sformatf("s3 done_c%0d", c), done, 1'b0);
            tick();
            if (pat[c]) acc++;
        end
        out_ready = 1'b0;
        check_val("s3 done_pulse", done, 1'b1);
        check_val("s3 valid_after", out_valid, 1'b0);
        tick();
        check_val("s3 busy_clear", busy, 1'b0);

        // Fault mask on the next-state field only
        out_ready = 1'b1;
        do_start(2, 8'h01);
        check_val("s4 frame0", out_frame, 16'h4000);
        tick();
        check_val("s4 frame1", out_frame, 16'hC841);
        check_val("s4 last1", out_last, 1'b1);
        tick();
        check_val("s4 done", done, 1'b1);
        tick();

        // Abort after two accepted frames; start during RUN must be ignored
        out_ready = 1'b1;
        do_start(8, 8'h00);
        check_val("s5 frame0", out_frame, exp_frame(0, 8'h00));
        start     = 1'b1;
        num_steps = 8'd1;
        tick();
        start     = 1'b0;
        num_steps = '0;
        check_val("s5 frame1", out_frame, exp_frame(1, 8'h00));
        check_val("s5 last1", out_last, 1'b0);
        tick();
        check_val("s5 frame2", out_frame, exp_frame(2, 8'h00));
        out_ready = 1'b0;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
        check_val("s5 abort_valid", out_valid, 1'b0);
        check_val("s5 abort_busy", busy, 1'b0);
        check_val("s5 abort_done", done, 1'b0);
        tick();
        check_val("s5 abort_done2", done, 1'b0);
        out_ready = 1'b1;
        do_start(2, 8'h00);
        check_val("s5 restart_frame0", out_frame, exp_frame(0, 8'h00));
        tick();
        check_val("s5 restart_frame1", out_frame, exp_frame(1, 8'h00));
        tick();
        check_val("s5 restart_done", done, 1'b1);
        tick();

        // Zero-length run
        do_start(0, 8'h00);
        check_val("s6 valid", out_valid, 1'b0);
        check_val("s6 done", done, 1'b1);
        check_val("s6 busy", busy, 1'b1);
        tick();
        check_val("s6 done_clear", done, 1'b0);
        check_val("s6 busy_clear", busy, 1'b0);

        // Asynchronous reset in the middle of a run
        out_ready = 1'b1;
        do_start(8, 8'h00);
        tick();
        check_val("s7 running", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("s7 rst_valid", out_valid, 1'b0);
        check_val("s7 rst_busy", busy, 1'b0);
        check_val("s7 rst_frame", out_frame, 16'h0000);
        check_val("s7 rst_last", out_last, 1'b0);
        tick();
        check_val("s7 rst_done", done, 1'b0);
        rst_n = 1'b1;
        tick();
        check_val("s7 post_done", done, 1'b0);
        check_val("s7 post_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
